// File: rtl/parity_tree_using_mux.sv
// parity_tree_using_mux: pipelined parity generator/checker built only from 2:1 muxes
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_data is reduced, in_odd/in_exp travel with the beat
//   out_valid/out_ready  result handshake; out_par is the parity, out_err flags out_par != expected
//   err_cnt/err_clr      saturating count of transferred error beats and its synchronous clear
module ptm_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module ptm_xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    logic b_n;
    ptm_mux2 u_inv (.sel(b), .d0(1'b1), .d1(1'b0), .y(b_n));
    ptm_mux2 u_xor (.sel(a), .d0(b), .d1(b_n), .y(y));
endmodule

module parity_tree_using_mux #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_odd,
    input  logic             in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);
    localparam int LAT = $clog2(WIDTH);
    localparam int N = 1 << LAT;
    logic             adv;
    logic [N-1:0]     pad;
    // All tree levels packed back to back: level s has N>>s nodes starting at bit N-2*(N>>s).
    logic [N-2:0]     tree_d, tree_q;
    logic [LAT:1]     vld_q, odd_q, exp_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    assign adv = !vld_q[LAT] || out_ready;
    assign in_ready = adv && !rst;
    assign pad = N'(in_data);
    for (genvar s = 1; s <= LAT; s++) begin : g_lvl
        localparam int M = N >> s;
        logic [2*M-1:0] a;
        logic [M-1:0]   x;
        if (s == 1) begin : g_first
            assign a = pad;
        end else begin : g_next
            assign a = tree_q[N-4*M+2*M-1:N-4*M];
        end
        for (genvar j = 0; j < M; j++) begin : g_node
            ptm_xor2 u_x (.a(a[2*j]), .b(a[2*j+1]), .y(x[j]));
        end
        assign tree_d[N-2*M+M-1:N-2*M] = x;
    end
    // The last register holds the raw data parity; odd selection and the check are folded in after it.
    ptm_xor2 u_odd (.a(tree_q[N-2]), .b(odd_q[LAT]), .y(out_par));
    ptm_xor2 u_chk (.a(out_par), .b(exp_q[LAT]), .y(out_err));
    assign out_valid = vld_q[LAT];
    assign err_cnt = cnt_q;
    assign cnt_d = err_clr ? '0 : (out_valid && out_ready && out_err && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tree_q <= '0;
            vld_q  <= '0;
            odd_q  <= '0;
            exp_q  <= '0;
        end else if (adv) begin
            tree_q <= tree_d;
            vld_q  <= LAT'({vld_q, in_valid});
            odd_q  <= LAT'({odd_q, in_odd});
            exp_q  <= LAT'({exp_q, in_exp});
        end
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: tb/tb_parity_tree_using_mux.sv
// tb_parity_tree_using_mux: randomized and directed checks of the mux-built parity pipeline
module tb_parity_tree_using_mux;
    logic clk = 1'b0;
    logic rst;
    logic a_in_valid, a_in_ready, a_in_odd, a_in_exp, a_out_valid, a_out_ready, a_out_par, a_out_err, a_err_clr;
    logic [7:0] a_in_data;
    logic [1:0] a_err_cnt;
    logic b_in_valid, b_in_ready, b_in_odd, b_in_exp, b_out_valid, b_out_ready, b_out_par, b_out_err, b_err_clr;
    logic [4:0] b_in_data;
    logic [7:0] b_err_cnt;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    int qt[$];

    always #5 clk = ~clk;

    parity_tree_using_mux #(.WIDTH(8), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_odd(a_in_odd), .in_exp(a_in_exp), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_par(a_out_par), .out_err(a_out_err), .err_cnt(a_err_cnt), .err_clr(a_err_clr)
    );

    parity_tree_using_mux #(.WIDTH(5), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_odd(b_in_odd), .in_exp(b_in_exp), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_par(b_out_par), .out_err(b_out_err), .err_cnt(b_err_cnt), .err_clr(b_err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_a(input logic [7:0] d, input logic o, input logic e);
        a_in_valid = 1'b1;
        a_in_data = d;
        a_in_odd = o;
        a_in_exp = e;
    endtask

    // {par, err}: parity is odd population of data plus the odd-select bit
    function automatic logic [1:0] ref_a(input logic [7:0] d, input logic o, input logic e);
        logic p;
        p = ($countones({d, o}) % 2) == 1;
        return {p, p != e};
    endfunction

    function automatic logic [1:0] ref_b(input logic [4:0] d, input logic o, input logic e);
        logic p;
        p = ($countones({d, o}) % 2) == 1;
        return {p, p != e};
    endfunction

    task automatic chk_a(input string tag, input logic v, input logic p, input logic e);
        check({tag, "_valid"}, 32'(a_out_valid), 32'(v));
        if (v) begin
            check({tag, "_par"}, 32'(a_out_par), 32'(p));
            check({tag, "_err"}, 32'(a_out_err), 32'(e));
        end
    endtask

    initial begin
        logic [1:0] e;
        logic hv, hp, he;
        int acnt, bcnt, bsent, t;
        rst = 1'b1;
        {a_in_valid, a_in_odd, a_in_exp, a_err_clr, b_in_valid, b_in_odd, b_in_exp, b_err_clr} = '0;
        a_in_data = '0;
        b_in_data = '0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready_a", 32'(a_in_ready), 0);
        check("rst_in_ready_b", 32'(b_in_ready), 0);
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out_par", 32'(a_out_par), 0);
        check("rst_out_err", 32'(a_out_err), 0);
        check("rst_err_cnt", 32'(a_err_cnt), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(a_in_ready), 1);
        send_a(8'hA5, 1'b0, 1'b0);
        tick();
        a_in_valid = 1'b0;
        tick();
        check("a5_early", 32'(a_out_valid), 0);
        tick();
        chk_a("a5", 1'b1, 1'b0, 1'b0);
        tick();
        check("a5_gone", 32'(a_out_valid), 0);
        send_a(8'h01, 1'b0, 1'b0);
        tick();
        send_a(8'hFF, 1'b1, 1'b1);
        tick();
        send_a(8'h7F, 1'b0, 1'b1);
        tick();
        a_in_valid = 1'b0;
        chk_a("b2b0", 1'b1, 1'b1, 1'b1);
        tick();
        chk_a("b2b1", 1'b1, 1'b1, 1'b0);
        check("b2b_cnt_mid", 32'(a_err_cnt), 1);
        tick();
        chk_a("b2b2", 1'b1, 1'b1, 1'b0);
        tick();
        check("b2b_done", 32'(a_out_valid), 0);
        check("b2b_cnt", 32'(a_err_cnt), 1);
        send_a(8'h0F, 1'b0, 1'b0);
        tick();
        send_a(8'h10, 1'b0, 1'b0);
        tick();
        a_in_valid = 1'b0;
        tick();
        a_out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_in_ready", 32'(a_in_ready), 0);
            chk_a("bp_hold", 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_a("bp_hold_end", 1'b1, 1'b0, 1'b0);
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 1);
        tick();
        chk_a("bp_second", 1'b1, 1'b1, 1'b1);
        check("bp_cnt_mid", 32'(a_err_cnt), 1);
        tick();
        check("bp_drained", 32'(a_out_valid), 0);
        check("bp_cnt", 32'(a_err_cnt), 2);
        for (int i = 0; i < 5; i++) begin
            send_a(8'h01, 1'b0, 1'b0);
            tick();
        end
        a_in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_cnt", 32'(a_err_cnt), 3);
        check("sat_drained", 32'(a_out_valid), 0);
        send_a(8'h01, 1'b0, 1'b0);
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        chk_a("clr_beat", 1'b1, 1'b1, 1'b1);
        check("clr_before", 32'(a_err_cnt), 3);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        check("clr_wins", 32'(a_err_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            send_a(8'h01, 1'b0, 1'b0);
            tick();
        end
        a_in_valid = 1'b0;
        check("mid_cnt", 32'(a_err_cnt), 1);
        check("mid_valid", 32'(a_out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(a_in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(a_err_cnt), 0);
        check("mid_rst_ready_after", 32'(a_in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_no_out", 32'(a_out_valid), 0);
            tick();
        end
        acnt = 0;
        for (int i = 0; i < 420; i++) begin
            a_in_valid = (i < 400) && ($urandom_range(0, 3) != 0);
            a_in_data = 8'($urandom);
            a_in_odd = 1'($urandom);
            a_in_exp = 1'($urandom);
            a_out_ready = (i >= 400) || ($urandom_range(0, 2) != 0);
            #1;
            check("rnd_in_ready", 32'(a_in_ready), 32'(!a_out_valid || a_out_ready));
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) check("rnd_spurious", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("rnd_par", 32'(a_out_par), 32'(e[1]));
                    check("rnd_err", 32'(a_out_err), 32'(e[0]));
                    if (e[0] && acnt != 3) acnt++;
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(ref_a(a_in_data, a_in_odd, a_in_exp));
            hv = a_out_valid && !a_out_ready;
            hp = a_out_par;
            he = a_out_err;
            tick();
            if (hv) begin
                check("rnd_hold_valid", 32'(a_out_valid), 1);
                check("rnd_hold_par", 32'(a_out_par), 32'(hp));
                check("rnd_hold_err", 32'(a_out_err), 32'(he));
            end
            check("rnd_cnt", 32'(a_err_cnt), 32'(acnt));
        end
        a_in_valid = 1'b0;
        check("rnd_lost", 32'(qa.size()), 0);
        bcnt = 0;
        bsent = 0;
        for (int i = 0; i < 1400; i++) begin
            b_in_valid = (bsent < 1000) && ($urandom_range(0, 7) != 0);
            b_in_data = 5'($urandom);
            b_in_odd = 1'($urandom);
            b_in_exp = 1'($urandom);
            #1;
            if (b_out_valid) begin
                if (qb.size() == 0) check("w5_spurious", 1, 0);
                else begin
                    e = qb.pop_front();
                    t = qt.pop_front();
                    check("w5_par", 32'(b_out_par), 32'(e[1]));
                    check("w5_err", 32'(b_out_err), 32'(e[0]));
                    check("w5_latency", 32'(cyc - t), 3);
                    if (e[0] && bcnt != 255) bcnt++;
                end
            end
            if (b_in_valid && b_in_ready) begin
                qb.push_back(ref_b(b_in_data, b_in_odd, b_in_exp));
                qt.push_back(cyc);
                bsent++;
            end
            tick();
            check("w5_cnt", 32'(b_err_cnt), 32'(bcnt));
        end
        b_in_valid = 1'b0;
        check("w5_sent", 32'(bsent), 1000);
        check("w5_lost", 32'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
